// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: RISC-V field widths,
// load/store opcode and funct3 codes, and the bus FSM encodings.
package mem_access_stage_pkg;

    localparam int RISCV_XLEN     = 32;
    localparam int RISCV_REG_W    = 5;
    localparam int RISCV_OPCODE_W = 7;
    localparam int RISCV_FUNCT3_W = 3;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [31:0] DEFAULT_32_ZERO = 32'h0;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic for the MEM stage: store strobe and data
// replication, load lane extraction with sign/zero extension.
module mem_align
    import mem_access_stage_pkg::*;
(
    input  logic [RISCV_FUNCT3_W-1:0] st_funct3,
    input  logic [1:0]                st_addr_lo,
    input  logic [RISCV_XLEN-1:0]     st_data,
    input  logic [RISCV_FUNCT3_W-1:0] ld_funct3,
    input  logic [1:0]                ld_addr_lo,
    input  logic [RISCV_XLEN-1:0]     ld_rdata,
    output logic [3:0]                wstrb,
    output logic [RISCV_XLEN-1:0]     wdata,
    output logic [RISCV_XLEN-1:0]     ld_data
);

    logic [RISCV_XLEN-1:0] lane;

    // Store side: strobe shifted to the addressed lane, data replicated
    always_comb begin
        wstrb = 4'b1111;
        wdata = st_data;
        case (st_funct3)
            FUNCT3_SB: begin
                wstrb = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            FUNCT3_SH: begin
                wstrb = 4'b0011 << st_addr_lo;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: shift addressed lane down, then extend
    always_comb begin
        lane    = ld_rdata >> {ld_addr_lo, 3'b000};
        ld_data = lane;
        case (ld_funct3)
            FUNCT3_LB:  ld_data = {{24{lane[7]}}, lane[7:0]};
            FUNCT3_LH:  ld_data = {{16{lane[15]}}, lane[15:0]};
            FUNCT3_LBU: ld_data = {24'h0, lane[7:0]};
            FUNCT3_LHU: ld_data = {16'h0, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: single-beat data-memory access with stall, timeout
// abort and misalignment trap; non-memory ops pass straight through.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                      clk,
    input  logic                      rest,
    input  logic                      in_valid_i,
    input  logic                      wb_en_i,
    input  logic [RISCV_OPCODE_W-1:0] opcode_i,
    input  logic [RISCV_FUNCT3_W-1:0] funct3_i,
    input  logic [RISCV_REG_W-1:0]    rd_i,
    input  logic [RISCV_XLEN-1:0]     mem_addr_i,
    input  logic [RISCV_XLEN-1:0]     store_data_i,
    output logic                      stall_o,
    output logic                      out_valid_o,
    output logic                      wb_en_o,
    output logic [RISCV_REG_W-1:0]    rd_o,
    output logic [RISCV_XLEN-1:0]     wb_data_o,
    output logic                      misalign_o,
    output logic                      bus_err_o,
    output logic [RISCV_XLEN-1:0]     fault_addr_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [RISCV_XLEN-1:0]     dmem_addr_o,
    output logic [3:0]                dmem_wstrb_o,
    output logic [RISCV_XLEN-1:0]     dmem_wdata_o,
    input  logic [RISCV_XLEN-1:0]     dmem_rdata_i,
    input  logic                      dmem_ack_i
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [RISCV_XLEN-1:0]     addr_q;
    logic [RISCV_FUNCT3_W-1:0] funct3_q;
    logic [RISCV_REG_W-1:0]    rd_q;
    logic                      wb_en_q;
    logic                      is_load, is_store, misal, accept, timeout;
    logic [3:0]                wstrb_c;
    logic [RISCV_XLEN-1:0]     wdata_c, ld_data_c;

    // Decode the incoming op and its alignment
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misal    = 1'b0;
        if (opcode_i == OPCODE_LOAD)
            is_load = funct3_i inside {FUNCT3_LB, FUNCT3_LH,
                FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
        if (opcode_i == OPCODE_STORE)
            is_store = funct3_i inside {FUNCT3_SB, FUNCT3_SH,
                FUNCT3_SW};
        if (funct3_i[1:0] == 2'b01)
            misal = mem_addr_i[0];
        else if (funct3_i[1:0] == 2'b10)
            misal = |mem_addr_i[1:0];
    end

    assign accept  = in_valid_i && (is_load || is_store) && !misal;
    assign timeout = (state == MEM_WAIT) && !dmem_ack_i
                     && (cnt == CNT_LAST);
    assign dmem_addr_o = {addr_q[31:2], 2'b00};

    mem_align u_align (
        .st_funct3  (funct3_i),
        .st_addr_lo (mem_addr_i[1:0]),
        .st_data    (store_data_i),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_q[1:0]),
        .ld_rdata   (dmem_rdata_i),
        .wstrb      (wstrb_c),
        .wdata      (wdata_c),
        .ld_data    (ld_data_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rest) begin
        if (rest) state <= MEM_IDLE;
        else      state <= state_nxt;
    end

    // FSM next state: ack or timeout ends the transaction
    always_comb begin
        state_nxt = state;
        case (state)
            MEM_IDLE: if (accept) state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ack_i || timeout) state_nxt = MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
    end

    // FSM outputs: request follows state so reset drops it at once
    always_comb begin
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        case (state)
            MEM_IDLE: stall_o = accept;
            MEM_WAIT: begin
                dmem_req_o = 1'b1;
                stall_o    = !dmem_ack_i && !timeout;
            end
            default: ;
        endcase
    end

    // Timeout counter: cleared on entry, counts unacked WAIT cycles
    always_ff @(posedge clk or posedge rest) begin
        if (rest)
            cnt <= '0;
        else if (state == MEM_IDLE)
            cnt <= '0;
        else if (!dmem_ack_i)
            cnt <= cnt + 1'b1;
    end

    // Request capture and result/fault registers toward MEM/WB
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            addr_q       <= DEFAULT_32_ZERO;
            funct3_q     <= '0;
            rd_q         <= '0;
            wb_en_q      <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_wstrb_o <= '0;
            dmem_wdata_o <= DEFAULT_32_ZERO;
            out_valid_o  <= 1'b0;
            wb_en_o      <= 1'b0;
            rd_o         <= '0;
            wb_data_o    <= DEFAULT_32_ZERO;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
            fault_addr_o <= DEFAULT_32_ZERO;
        end else begin
            out_valid_o <= 1'b0;
            wb_en_o     <= 1'b0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            if (state == MEM_IDLE) begin
                if (accept) begin
                    addr_q       <= mem_addr_i;
                    funct3_q     <= funct3_i;
                    rd_q         <= rd_i;
                    wb_en_q      <= wb_en_i;
                    dmem_we_o    <= is_store;
                    dmem_wstrb_o <= wstrb_c;
                    dmem_wdata_o <= wdata_c;
                end else if (in_valid_i && (is_load || is_store)) begin
                    out_valid_o  <= 1'b1;
                    misalign_o   <= 1'b1;
                    fault_addr_o <= mem_addr_i;
                end else if (in_valid_i) begin
                    out_valid_o <= 1'b1;
                    wb_en_o     <= wb_en_i;
                    rd_o        <= rd_i;
                    wb_data_o   <= mem_addr_i;
                end
            end else if (dmem_ack_i) begin
                out_valid_o <= 1'b1;
                wb_en_o     <= wb_en_q && !dmem_we_o;
                rd_o        <= rd_q;
                if (!dmem_we_o) wb_data_o <= ld_data_c;
            end else if (timeout) begin
                out_valid_o  <= 1'b1;
                bus_err_o    <= 1'b1;
                fault_addr_o <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected write-back results
// are queued at issue time and checked by an independent monitor.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        wb_en_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] store_data_i = '0;
    logic [31:0] dmem_rdata_i = '0;
    logic        dmem_ack_i = 1'b0;
    logic        stall_o, out_valid_o, wb_en_o;
    logic [4:0]  rd_o;
    logic [31:0] wb_data_o, fault_addr_o;
    logic        misalign_o, bus_err_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;

    typedef struct {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        misal;
        logic        berr;
        logic [31:0] fault;
        logic        chk_fault;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    mem_access_stage dut (
        .clk          (clk),
        .rest         (rest),
        .in_valid_i   (in_valid_i),
        .wb_en_i      (wb_en_i),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .rd_i         (rd_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .out_valid_o  (out_valid_o),
        .wb_en_o      (wb_en_o),
        .rd_o         (rd_o),
        .wb_data_o    (wb_data_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .fault_addr_o (fault_addr_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wstrb_o (dmem_wstrb_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic void push(input logic wb_en,
                                 input logic [4:0] rd,
                                 input logic [31:0] data,
                                 input logic chk_data,
                                 input logic misal,
                                 input logic berr,
                                 input logic [31:0] fault,
                                 input logic chk_fault);
        exp_t e;
        e.wb_en = wb_en; e.rd = rd; e.data = data;
        e.chk_data = chk_data; e.misal = misal; e.berr = berr;
        e.fault = fault; e.chk_fault = chk_fault;
        q.push_back(e);
    endfunction

    // Monitor: every out_valid_o must match the oldest queued entry
    always @(negedge clk) begin
        if (!rest && out_valid_o) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wb_en_o", 32'(wb_en_o), 32'(e.wb_en));
                check("misalign_o", 32'(misalign_o), 32'(e.misal));
                check("bus_err_o", 32'(bus_err_o), 32'(e.berr));
                if (e.chk_data) begin
                    check("rd_o", 32'(rd_o), 32'(e.rd));
                    check("wb_data_o", wb_data_o, e.data);
                end
                if (e.chk_fault)
                    check("fault_addr_o", fault_addr_o, e.fault);
            end
        end
    end

    task automatic drv(input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] addr,
                       input logic [31:0] sd, input logic wben);
        in_valid_i = 1'b1; opcode_i = op; funct3_i = f3;
        rd_i = rd; mem_addr_i = addr; store_data_i = sd;
        wb_en_i = wben;
    endtask

    // Issue one aligned memory op, acking in WAIT cycle ack_at
    task automatic mem_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdata,
                          input int ack_at, input logic [31:0] e_addr,
                          input logic e_we, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata);
        @(posedge clk); #1;
        drv(op, f3, rd, addr, sd, 1'b1);
        @(negedge clk);
        check("accept_stall", 32'(stall_o), 32'd1);
        check("accept_no_req", 32'(dmem_req_o), 32'd0);
        for (int c = 1; c <= ack_at; c++) begin
            @(posedge clk); #1;
            if (c == ack_at) begin
                dmem_ack_i = 1'b1;
                dmem_rdata_i = rdata;
            end
            @(negedge clk);
            check("wait_req", 32'(dmem_req_o), 32'd1);
            check("wait_stall", 32'(stall_o), 32'(c != ack_at));
            if (c == 1) begin
                check("dmem_addr", dmem_addr_o, e_addr);
                check("dmem_we", 32'(dmem_we_o), 32'(e_we));
                if (e_we) begin
                    check("dmem_wstrb", 32'(dmem_wstrb_o), 32'(e_strb));
                    check("dmem_wdata", dmem_wdata_o, e_wdata);
                end
            end
        end
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        in_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset values
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_fault", fault_addr_o, 32'd0);
        check("rst_wstrb", 32'(dmem_wstrb_o), 32'd0);
        @(negedge clk);
        rest = 1'b0;

        // ADD pass-through
        push(1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk); #1;
        drv(7'b0110011, 3'b000, 5'd5, 32'h1234, 32'h0, 1'b1);
        @(negedge clk);
        check("add_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        dmem_ack_i = 1'b1;
        @(negedge clk);
        check("add_stall2", 32'(stall_o), 32'd0);
        // Idle cycle with a spurious ack: nothing happens, data holds
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid_o), 32'd0);
        check("idle_hold_data", wb_data_o, 32'h1234);
        check("idle_hold_rd", 32'(rd_o), 32'd5);
        check("idle_req", 32'(dmem_req_o), 32'd0);

        // LB sign-extend, ack in second WAIT cycle
        push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        mem_op(OPCODE_LOAD, FUNCT3_LB, 5'd7, 32'h103, 32'h0,
               32'h80FF_FF00, 2, 32'h100, 1'b0, 4'h0, 32'h0);

        // LHU zero-extend from upper half, immediate ack
        push(1'b1, 5'd9, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        mem_op(OPCODE_LOAD, FUNCT3_LHU, 5'd9, 32'h102, 32'h0,
               32'h8001_7FFF, 1, 32'h100, 1'b0, 4'h0, 32'h0);

        // SH at 0x202
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        mem_op(OPCODE_STORE, FUNCT3_SH, 5'd3, 32'h202, 32'hABCD_1234,
               32'h0, 1, 32'h200, 1'b1, 4'b1100, 32'h1234_1234);

        // SB at 0x001
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        mem_op(OPCODE_STORE, FUNCT3_SB, 5'd3, 32'h001, 32'h1234_5655,
               32'h0, 1, 32'h000, 1'b1, 4'b0010, 32'h5555_5555);

        // Misaligned LW
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h305, 1'b1);
        @(posedge clk); #1;
        drv(OPCODE_LOAD, FUNCT3_LW, 5'd4, 32'h305, 32'h0, 1'b1);
        @(negedge clk);
        check("misal_stall", 32'(stall_o), 32'd0);
        check("misal_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        check("misal_req2", 32'(dmem_req_o), 32'd0);

        // SW without ack: timeout after 16 WAIT cycles
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1);
        @(posedge clk); #1;
        drv(OPCODE_STORE, FUNCT3_SW, 5'd0, 32'h400, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dmem_req_o) n++;
            if (i == 0)
                check("sw_wstrb", 32'(dmem_wstrb_o), 32'hF);
            if (!stall_o) break;
        end
        check("timeout_stall_release", 32'(stall_o), 32'd0);
        check("timeout_req_cycles", 32'(n), 32'd16);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        check("timeout_req_drop", 32'(dmem_req_o), 32'd0);

        // SW with ack exactly on WAIT cycle 16: no error
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        mem_op(OPCODE_STORE, FUNCT3_SW, 5'd0, 32'h404, 32'h0BAD_F00D,
               32'h0, 16, 32'h404, 1'b1, 4'hF, 32'h0BAD_F00D);

        // Reset in the middle of an LW transaction
        @(posedge clk); #1;
        drv(OPCODE_LOAD, FUNCT3_LW, 5'd6, 32'h500, 32'h0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_req", 32'(dmem_req_o), 32'd1);
        #1 rest = 1'b1;
        #1;
        check("async_req_drop", 32'(dmem_req_o), 32'd0);
        in_valid_i = 1'b0;
        @(negedge clk);
        rest = 1'b0;
        check("post_rst_state", 32'(dut.state), 32'(MEM_IDLE));
        check("post_rst_wb_data", wb_data_o, 32'd0);
        check("post_rst_rd", 32'(rd_o), 32'd0);
        check("post_rst_we", 32'(dmem_we_o), 32'd0);
        repeat (3) @(negedge clk);
        check("post_rst_req", 32'(dmem_req_o), 32'd0);
        check("post_rst_stall", 32'(stall_o), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
